// File: rtl/cmd_sequencer.sv
// cmd_sequencer: buffers 16-bit commands from the UART wrapper in a small FIFO,
// dispatches them in order to the motion executor over a go/done handshake and
// returns exactly one response byte per command through the UART transmitter.
// Optional feature macro CMD_TIMEOUT_EN: adds an executor watchdog that aborts a
// command stalled for TIMEOUT_CYC cycles and answers 8'hEE instead of ACK.
module cmd_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [7:0]  ACK         = 8'hA5,
  parameter logic [7:0]  NAK         = 8'h5A,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                cmd,
  input  logic                       cmd_rdy,
  output logic                       clr_cmd_rdy,
  output logic [7:0]                 resp,
  output logic                       trmt,
  input  logic                       tx_done,
  output logic                       exe_go,
  output logic [3:0]                 exe_op,
  output logic [11:0]                exe_arg,
  input  logic                       exe_done,
  output logic                       exe_abort,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_CAL  = 4'h4;
  localparam logic [3:0] OP_TOUR = 4'h6;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT_DONE,
    RESP,
    WAIT_TX
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     resp_q, resp_d;
  logic           trmt_q, trmt_d;
  logic           go_q, go_d;
  logic [3:0]     op_q, op_d;
  logic [11:0]    arg_q, arg_d;
  logic           busy_q, busy_d;
  logic           guard_q, guard_d;

  logic           full;
  logic           push;
  logic           pop;
  logic [15:0]    head;
  logic           legal;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]  TMO_RESP = 8'hEE;

  logic [TW-1:0]  tmr_q, tmr_d;
  logic           abort_q, abort_d;

  assign exe_abort = abort_q;
`else
  assign exe_abort = 1'b0;
`endif

  assign full        = (cnt_q == CW'(DEPTH));
  assign push        = cmd_rdy & ~full;
  assign pop         = (state_q == IDLE) && (cnt_q != '0);
  assign head        = fifo_mem[rd_ptr_q];
  assign legal       = (head[15:12] == OP_MOVE) || (head[15:12] == OP_CAL) ||
                       (head[15:12] == OP_TOUR);

  assign clr_cmd_rdy = push;
  assign resp        = resp_q;
  assign trmt        = trmt_q;
  assign exe_go      = go_q;
  assign exe_op      = op_q;
  assign exe_arg     = arg_q;
  assign busy        = busy_q;
  assign fifo_cnt    = cnt_q;

  // FIFO storage: write the incoming command at the tail on every accepted push.
  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are valid, so clearing the data would cost logic for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= cmd;
    end
  end

  // Next-state logic for FIFO pointers/occupancy and the dispatch FSM outputs.
  // NOTE: every signal gets a default at the top of this block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    resp_d   = resp_q;
    trmt_d   = 1'b0;
    go_d     = 1'b0;
    op_d     = op_q;
    arg_d    = arg_q;
    guard_d  = 1'b0;
`ifdef CMD_TIMEOUT_EN
    tmr_d    = tmr_q;
    abort_d  = 1'b0;
`endif

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    case (state_q)
      IDLE: begin
        if (pop) begin
          if (legal) begin
            op_d    = head[15:12];
            arg_d   = head[11:0];
            go_d    = 1'b1;
            state_d = DISPATCH;
          end else begin
            // Illegal opcode: answer directly, the executor never sees it.
            resp_d  = NAK;
            trmt_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      DISPATCH: begin
        state_d = WAIT_DONE;
`ifdef CMD_TIMEOUT_EN
        tmr_d   = '0;
`endif
      end
      WAIT_DONE: begin
        // A completion arriving on the watchdog's last cycle still counts as success.
        if (exe_done) begin
          resp_d  = ACK;
          trmt_d  = 1'b1;
          state_d = RESP;
        end
`ifdef CMD_TIMEOUT_EN
        else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
          abort_d = 1'b1;
          resp_d  = TMO_RESP;
          trmt_d  = 1'b1;
          state_d = RESP;
        end else begin
          tmr_d   = tmr_q + TW'(1);
        end
`endif
      end
      RESP: begin
        guard_d = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        // The first cycle here ignores tx_done, which may still be high from
        // the previous byte.
        if (!guard_q && tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; async reset abandons any command in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values computed for this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      resp_q   <= 8'h00;
      trmt_q   <= 1'b0;
      go_q     <= 1'b0;
      op_q     <= '0;
      arg_q    <= '0;
      busy_q   <= 1'b0;
      guard_q  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmr_q    <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      resp_q   <= resp_d;
      trmt_q   <= trmt_d;
      go_q     <= go_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      busy_q   <= busy_d;
      guard_q  <= guard_d;
`ifdef CMD_TIMEOUT_EN
      tmr_q    <= tmr_d;
      abort_q  <= abort_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: directed handshake timing, FIFO full
// back-pressure, reset flush, watchdog (CMD_TIMEOUT_EN) and a randomized command
// stream scored against an in-order reference model.
`timescale 1ns/1ps
module tb_cmd_sequencer;

  localparam int         DEPTH    = 4;
  localparam int         TMO_CYC  = 16;
  localparam int         CW       = $clog2(DEPTH + 1);
  localparam logic [7:0] ACK      = 8'hA5;
  localparam logic [7:0] NAK      = 8'h5A;
  localparam logic [7:0] TMO_RESP = 8'hEE;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [15:0]   cmd      = '0;
  logic          cmd_rdy  = 1'b0;
  logic          tx_done  = 1'b0;
  logic          exe_done = 1'b0;
  logic          clr_cmd_rdy;
  logic [7:0]    resp;
  logic          trmt;
  logic          exe_go;
  logic [3:0]    exe_op;
  logic [11:0]   exe_arg;
  logic          exe_abort;
  logic          busy;
  logic [CW-1:0] fifo_cnt;

  int            checks   = 0;
  int            errors   = 0;
  bit            exe_auto = 1'b0;
  bit            tx_auto  = 1'b0;
  int unsigned   exe_dly;
  int unsigned   tx_dly;
  int            abort_cnt = 0;

  logic [15:0]   go_log[$];
  logic [7:0]    resp_log[$];
  logic [15:0]   exp_q[$];

  cmd_sequencer #(
    .DEPTH      (DEPTH),
    .ACK        (ACK),
    .NAK        (NAK),
    .TIMEOUT_CYC(TMO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .exe_go     (exe_go),
    .exe_op     (exe_op),
    .exe_arg    (exe_arg),
    .exe_done   (exe_done),
    .exe_abort  (exe_abort),
    .busy       (busy),
    .fifo_cnt   (fifo_cnt)
  );

  initial forever #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  // Monitor: record every dispatch and every transmitted byte.
  initial forever begin
    @(negedge clk);
    if (exe_go === 1'b1)    go_log.push_back({exe_op, exe_arg});
    if (trmt === 1'b1)      resp_log.push_back(resp);
    if (exe_abort === 1'b1) abort_cnt++;
  end

  // Executor model: completes each dispatched command after a random delay.
  initial forever begin
    @(negedge clk);
    if (exe_go === 1'b1 && exe_auto) begin
      exe_dly = $urandom_range(1, 6);
      repeat (exe_dly) @(posedge clk);
      #1 exe_done = 1'b1;
      @(posedge clk);
      #1 exe_done = 1'b0;
    end
  end

  // Transmitter model: reports tx_done a few cycles after each trmt strobe.
  initial forever begin
    @(negedge clk);
    if (trmt === 1'b1 && tx_auto) begin
      tx_dly = $urandom_range(2, 4);
      repeat (tx_dly) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return (op == 4'h2) || (op == 4'h4) || (op == 4'h6);
  endfunction

  function automatic logic [3:0] rand_legal();
    case ($urandom_range(0, 2))
      0:       return 4'h2;
      1:       return 4'h4;
      default: return 4'h6;
    endcase
  endfunction

  // Offer one command like the wrapper does: hold cmd_rdy until accepted.
  task automatic push_cmd(input logic [15:0] c);
    int n;
    n = 0;
    cmd = c;
    cmd_rdy = 1'b1;
    #1;
    while (clr_cmd_rdy !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (clr_cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL push_accept: clr_cmd_rdy=%b after %0d cycles, expected 1", clr_cmd_rdy, n);
    end else begin
      exp_q.push_back(c);
    end
    step();
    cmd_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(busy === 1'b0 && fifo_cnt === '0) && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || fifo_cnt !== '0) begin
      errors++;
      $display("FAIL %s_drain: busy=%b fifo_cnt=%0d, expected idle and empty", tag, busy, fifo_cnt);
    end
    repeat (6) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if (fifo_cnt !== '0) begin
      errors++; $display("FAIL reset_fifo_cnt: got %0d expected 0", fifo_cnt);
    end
    checks++;
    if ({trmt, exe_go, exe_abort, busy, clr_cmd_rdy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: trmt/go/abort/busy/clr=%b expected 00000",
               {trmt, exe_go, exe_abort, busy, clr_cmd_rdy});
    end
    checks++;
    if (resp !== 8'h00 || exe_op !== 4'h0 || exe_arg !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: resp=%h op=%h arg=%h expected 00 0 000", resp, exe_op, exe_arg);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    cmd = 16'h2123;
    cmd_rdy = 1'b1;
    #1;
    checks++;
    if (clr_cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL single_clr: got %b expected 1", clr_cmd_rdy);
    end
    step();                         // cycle N+1
    cmd_rdy = 1'b0;
    checks++;
    if (exe_go !== 1'b0) begin
      errors++; $display("FAIL single_go_early: exe_go=%b in cycle N+1, expected 0", exe_go);
    end
    step();                         // cycle N+2
    checks++;
    if (exe_go !== 1'b1 || exe_op !== 4'h2 || exe_arg !== 12'h123) begin
      errors++;
      $display("FAIL single_go: go=%b op=%h arg=%h expected 1 2 123", exe_go, exe_op, exe_arg);
    end
    exe_done = 1'b1;                // stray completion while still dispatching
    step();
    exe_done = 1'b0;
    checks++;
    if (exe_go !== 1'b0 || trmt !== 1'b0 || busy !== 1'b1 || exe_op !== 4'h2) begin
      errors++;
      $display("FAIL single_wait: go=%b trmt=%b busy=%b op=%h expected 0 0 1 2",
               exe_go, trmt, busy, exe_op);
    end
    step();
    exe_done = 1'b1;
    step();
    exe_done = 1'b0;
    checks++;
    if (trmt !== 1'b1 || resp !== ACK) begin
      errors++; $display("FAIL single_resp: trmt=%b resp=%h expected 1 %h", trmt, resp, ACK);
    end
    step();                         // first WAIT_TX cycle
    checks++;
    if (trmt !== 1'b0) begin
      errors++; $display("FAIL single_trmt_len: trmt=%b expected 0", trmt);
    end
    tx_done = 1'b1;                 // seen during the guard cycle, must be ignored
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single_tx_guard: busy=%b expected 1", busy);
    end
    step();
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || resp !== ACK) begin
      errors++; $display("FAIL single_done: busy=%b resp=%h expected 0 %h", busy, resp, ACK);
    end
  endtask

  task automatic test_illegal();
    int go_n;
    go_n = go_log.size();
    cmd = 16'hF000;
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    step();
    checks++;
    if (trmt !== 1'b1 || resp !== NAK) begin
      errors++; $display("FAIL illegal_resp: trmt=%b resp=%h expected 1 %h", trmt, resp, NAK);
    end
    step();
    tx_done = 1'b1;
    step();
    step();
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || go_log.size() !== go_n) begin
      errors++;
      $display("FAIL illegal_no_exec: busy=%b dispatches=%0d expected 0 %0d",
               busy, go_log.size(), go_n);
    end
  endtask

  task automatic test_full();
    logic [15:0] c;
    int bad;
    exe_auto = 1'b0;
    tx_auto  = 1'b0;
    exp_q.delete();
    go_log.delete();
    for (int i = 0; i < 5; i++) begin
      c = {rand_legal(), 12'($urandom)};
      cmd = c;
      cmd_rdy = 1'b1;
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b1) begin
        errors++; $display("FAIL full_push%0d: clr_cmd_rdy=%b expected 1", i, clr_cmd_rdy);
      end
      exp_q.push_back(c);
      step();
    end
    c = {rand_legal(), 12'($urandom)};
    cmd = c;
    #1;
    checks++;
    if (fifo_cnt !== CW'(DEPTH) || clr_cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_level: fifo_cnt=%0d clr=%b expected %0d 0", fifo_cnt, clr_cmd_rdy, DEPTH);
    end
    bad = 0;
    repeat (4) begin
      step();
      if (clr_cmd_rdy !== 1'b0 || fifo_cnt !== CW'(DEPTH)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_hold: %0d cycles accepted or drained, expected 0", bad);
    end
    exe_auto = 1'b1;
    tx_auto  = 1'b1;
    exe_done = 1'b1;
    step();
    exe_done = 1'b0;
    push_cmd(c);
    checks++;
    if (fifo_cnt !== CW'(DEPTH)) begin
      errors++; $display("FAIL full_refill: fifo_cnt=%0d expected %0d", fifo_cnt, DEPTH);
    end
    wait_idle("full");
    checks++;
    if (go_log.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL full_go_count: got %0d dispatches expected %0d", go_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
      checks++;
      if (go_log[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_go_order[%0d]: got %h expected %h", i, go_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp_go[$];
    logic [7:0]  exp_resp[$];
    logic [3:0]  op;
    exe_auto = 1'b1;
    tx_auto  = 1'b1;
    exp_q.delete();
    go_log.delete();
    resp_log.delete();
    abort_cnt = 0;
    push_cmd({4'h2, 12'($urandom)});
    push_cmd({4'h4, 12'($urandom)});
    push_cmd({4'h9, 12'($urandom)});
    push_cmd({4'h6, 12'($urandom)});
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) < 6) ? rand_legal() : 4'($urandom_range(0, 15));
      push_cmd({op, 12'($urandom)});
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle("stream");
    foreach (exp_q[i]) begin
      if (is_legal(exp_q[i][15:12])) exp_go.push_back(exp_q[i]);
      exp_resp.push_back(is_legal(exp_q[i][15:12]) ? ACK : NAK);
    end
    checks++;
    if (go_log.size() !== exp_go.size() || resp_log.size() !== exp_resp.size()) begin
      errors++;
      $display("FAIL stream_counts: dispatches=%0d responses=%0d expected %0d %0d",
               go_log.size(), resp_log.size(), exp_go.size(), exp_resp.size());
    end
    for (int i = 0; i < exp_go.size() && i < go_log.size(); i++) begin
      checks++;
      if (go_log[i] !== exp_go[i]) begin
        errors++; $display("FAIL stream_go[%0d]: got %h expected %h", i, go_log[i], exp_go[i]);
      end
    end
    for (int i = 0; i < exp_resp.size() && i < resp_log.size(); i++) begin
      checks++;
      if (resp_log[i] !== exp_resp[i]) begin
        errors++; $display("FAIL stream_resp[%0d]: got %h expected %h", i, resp_log[i], exp_resp[i]);
      end
    end
    checks++;
    if (abort_cnt != 0) begin
      errors++; $display("FAIL stream_abort: %0d abort pulses expected 0", abort_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    exe_auto = 1'b0;
    tx_auto  = 1'b0;
    push_cmd({4'h2, 12'($urandom)});
    push_cmd({4'h4, 12'($urandom)});
    push_cmd({4'h6, 12'($urandom)});
    checks++;
    if (fifo_cnt !== CW'(2) || busy !== 1'b1 || exe_go !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_setup: fifo_cnt=%0d busy=%b go=%b expected 2 1 0", fifo_cnt, busy, exe_go);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_cnt !== '0 || busy !== 1'b0 || resp !== 8'h00 || exe_op !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_flush: fifo_cnt=%0d busy=%b resp=%h op=%h expected 0 0 00 0",
               fifo_cnt, busy, resp, exe_op);
    end
    step();
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      step();
      if (trmt !== 1'b0 || exe_go !== 1'b0 || busy !== 1'b0 || fifo_cnt !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rstmid_quiet: %0d active cycles after reset expected 0", bad);
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    int n, early;
    exe_auto = 1'b0;
    tx_auto  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push_cmd({4'h4, 12'($urandom)});
      n = 0;
      while (exe_go !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (exe_go !== 1'b1) begin
        errors++; $display("FAIL tmo_go%0d: exe_go=%b expected 1", k, exe_go);
      end
      // TMO_CYC cycles in WAIT_DONE, then the answer appears in the next cycle.
      early = 0;
      for (int c = 1; c <= TMO_CYC + 1; c++) begin
        step();
        exe_done = 1'b0;
        if (c <= TMO_CYC && (exe_abort !== 1'b0 || trmt !== 1'b0)) early++;
        if (k == 1 && c == TMO_CYC) exe_done = 1'b1;
      end
      checks++;
      if (early != 0) begin
        errors++; $display("FAIL tmo_early%0d: %0d early strobes expected 0", k, early);
      end
      checks++;
      if (trmt !== 1'b1 || exe_abort !== (k == 0) || resp !== ((k == 0) ? TMO_RESP : ACK)) begin
        errors++;
        $display("FAIL tmo_resp%0d: trmt=%b abort=%b resp=%h expected 1 %b %h",
                 k, trmt, exe_abort, resp, (k == 0), (k == 0) ? TMO_RESP : ACK);
      end
      step();
      checks++;
      if (exe_abort !== 1'b0) begin
        errors++; $display("FAIL tmo_abort_len%0d: exe_abort=%b expected 0", k, exe_abort);
      end
      tx_done = 1'b1;
      step();
      step();
      tx_done = 1'b0;
    end
  endtask
`else
  task automatic test_no_timeout();
    int n, bad;
    exe_auto = 1'b0;
    tx_auto  = 1'b0;
    push_cmd({4'h6, 12'($urandom)});
    n = 0;
    while (exe_go !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (exe_go !== 1'b1) begin
      errors++; $display("FAIL stall_go: exe_go=%b expected 1", exe_go);
    end
    bad = 0;
    repeat (40) begin
      step();
      if (trmt !== 1'b0 || exe_abort !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_wait: %0d cycles left WAIT_DONE expected 0", bad);
    end
    exe_done = 1'b1;
    step();
    exe_done = 1'b0;
    checks++;
    if (trmt !== 1'b1 || resp !== ACK) begin
      errors++; $display("FAIL stall_resp: trmt=%b resp=%h expected 1 %h", trmt, resp, ACK);
    end
    step();
    tx_done = 1'b1;
    step();
    step();
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stall_done: busy=%b expected 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_full();
    test_stream();
    test_reset_mid();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Sits directly downstream of the UART command wrapper.
- Consumes each assembled 16-bit command (cmd / cmd_rdy) and acknowledges it with clr_cmd_rdy. Commands are buffered in a small FIFO.
- Each command is dispatched in order to the motion executor over a go/done handshake.
- Exactly one response byte per command goes back through the wrapper's transmit path (resp / trmt / tx_done).

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- ACK, 8'hA5, response byte for a command executed successfully
- NAK, 8'h5A, response byte for an illegal opcode
- TIMEOUT_CYC, 1000000, executor watchdog limit in clk cycles (used only with CMD_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- cmd  in  16  command word from the UART wrapper; [15:12] opcode, [11:0] argument
- cmd_rdy  in  1  cmd valid, level
- clr_cmd_rdy  out  1  command accepted; combinational, equals cmd_rdy & ~full
- resp  out  8  response byte to the UART transmitter
- trmt  out  1  one-cycle transmit strobe
- tx_done  in  1  transmitter finished, level
- exe_go  out  1  one-cycle start strobe to the executor
- exe_op  out  4  opcode of the current command, held stable from exe_go until exe_done
- exe_arg  out  12  argument of the current command, held with exe_op
- exe_done  in  1  one-cycle executor completion pulse
- exe_abort  out  1  one-cycle abort strobe (constant 0 without CMD_TIMEOUT_EN)
- busy  out  1  state != IDLE
- fifo_cnt  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - state IDLE, FIFO empty, fifo_cnt=0.
  - resp=8'h00; trmt, exe_go, exe_abort, busy all 0; exe_op, exe_arg = 0.
  - Asserting rst mid-operation abandons the current command and flushes the FIFO; no trmt or exe_go is issued afterwards.
- Push:
  - On any edge where cmd_rdy=1 and fifo_cnt<DEPTH, cmd is written at the tail.
  - Same cycle clr_cmd_rdy=1; the wrapper drops cmd_rdy at that edge, so there is no double push.
- Full:
  - clr_cmd_rdy=0 and the command is left pending.
  - It is pushed on the first cycle an entry frees up.
- Simultaneous push and pop: fifo_cnt unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, DISPATCH, WAIT_DONE, RESP, WAIT_TX.
  - IDLE: if FIFO non-empty, pop the head into the cur register.
    - Legal opcode (4'h2 MOVE, 4'h4 CAL, 4'h6 TOUR): go to DISPATCH.
    - Otherwise: resp<=NAK, go to RESP; the executor is never touched.
  - DISPATCH: exe_go=1 for exactly one cycle, exe_op/exe_arg driven from cur; go to WAIT_DONE.
  - WAIT_DONE: on exe_done, resp<=ACK, go to RESP.
    - exe_done seen outside WAIT_DONE is ignored.
  - RESP: trmt=1 for one cycle; go to WAIT_TX.
  - WAIT_TX: tx_done ignored in the first cycle (guard for a stale level); afterwards tx_done=1 returns to IDLE.
- Latency: with the FIFO empty and state IDLE, cmd_rdy high in cycle N gives exe_go high in cycle N+2.
- Ordering: commands are executed strictly in FIFO order, with exactly one response per popped command.
- Pushes continue in every state, so buffering overlaps execution.
- resp holds its last value between transmissions.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_DONE and increments each cycle there.
  - When it reaches TIMEOUT_CYC-1 without exe_done: exe_abort=1 for one cycle, resp<=8'hEE, go to RESP.
  - If exe_done and timeout occur in the same cycle, exe_done wins and ACK is sent.
- Undefined: no counter; exe_abort tied 0; WAIT_DONE waits indefinitely.

Test Plan:
- Reset then cmd=16'h2123 for one cycle (clr_cmd_rdy=1 same cycle) -> exe_go 2 cycles later with exe_op=4'h2, exe_arg=12'h123; exe_done -> trmt with resp=8'hA5; tx_done -> busy=0.
- cmd=16'hF000 -> no exe_go; trmt with resp=8'h5A.
- Executor stalled; push 5 commands back-to-back (DEPTH=4) -> 1 popped, 4 buffered (fifo_cnt=4); 6th cmd_rdy held with clr_cmd_rdy=0 until pop frees an entry, then accepted.
- Stream 4'h2, 4'h4, 4'h9, 4'h6 -> exe_go order 2, 4, 6; resp sequence A5, A5, 5A, A5.
- rst asserted in WAIT_DONE with 2 entries queued -> fifo_cnt=0, state IDLE, and no trmt in the 20 cycles after release.
- CMD_TIMEOUT_EN with TIMEOUT_CYC=16 and no exe_done -> exe_abort pulse, then resp=8'hEE via trmt; exe_done on the final cycle instead -> resp=8'hA5.
